// File: rtl/funcq_arbiter.sv
// Round-robin arbiter that shares one in-order funcQ datapath among NUM_REQ clients.
// Requester IDs ride an in-order tag FIFO so each funcQ result returns to its originator.
module funcq_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUT    = 8,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
    output logic                          data_vld,
    output logic signed [DATA_WIDTH-1:0]  a,
    output logic signed [DATA_WIDTH-1:0]  b,
    output logic signed [DATA_WIDTH-1:0]  c,
    output logic signed [DATA_WIDTH-1:0]  d,
    input  logic                          Q_vld,
    input  logic signed [DATA_WIDTH-1:0]  Q,
    output logic                          resp_vld,
    output logic [ID_W-1:0]               resp_id,
    output logic signed [DATA_WIDTH-1:0]  resp_q,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    data_t op_a [NUM_REQ];
    data_t op_b [NUM_REQ];
    data_t op_c [NUM_REQ];
    data_t op_d [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign op_b[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
        assign op_c[g] = req_c[g*DATA_WIDTH +: DATA_WIDTH];
        assign op_d[g] = req_d[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]  tag_mem_q [MAX_OUT];
    logic [ID_W-1:0]  tag_mem_d [MAX_OUT];
    logic             data_vld_q, data_vld_d;
    data_t            a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic             resp_vld_q, resp_vld_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    data_t            resp_q_q, resp_q_d;
    logic             busy_q, busy_d;
    logic             err_orphan_q, err_orphan_d;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  scan_id;
    logic             full;
    logic             push;
    logic             pop;

    // First valid requester found scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_vld[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
    end

    assign full = (count_q == CNT_W'(MAX_OUT));
    assign push = rst & grant_vld & ~full;
    assign pop  = rst & Q_vld & (count_q != '0);

    always_comb begin
        req_rdy = '0;
        if (push) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_mem_d    = tag_mem_q;
        data_vld_d   = push;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        resp_vld_d   = pop;
        resp_id_d    = resp_id_q;
        resp_q_d     = resp_q_q;
        err_orphan_d = err_orphan_q | (Q_vld & (count_q == '0));

        if (push) begin
            a_d                 = op_a[grant_id];
            b_d                 = op_b[grant_id];
            c_d                 = op_c[grant_id];
            d_d                 = op_d[grant_id];
            tag_mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            ptr_d               = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end

        if (pop) begin
            resp_id_d = tag_mem_q[rd_ptr_q];
            resp_q_d  = Q;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q        <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_mem_q    <= '{default: '0};
            data_vld_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            resp_vld_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_q_q     <= '0;
            busy_q       <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_mem_q    <= tag_mem_d;
            data_vld_q   <= data_vld_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            resp_vld_q   <= resp_vld_d;
            resp_id_q    <= resp_id_d;
            resp_q_q     <= resp_q_d;
            busy_q       <= busy_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign data_vld   = data_vld_q;
    assign a          = a_q;
    assign b          = b_q;
    assign c          = c_q;
    assign d          = d_q;
    assign resp_vld   = resp_vld_q;
    assign resp_id    = resp_id_q;
    assign resp_q     = resp_q_q;
    assign busy       = busy_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_funcq_arbiter.sv
// Bench for funcq_arbiter: queue-based reference of requesters, tag order and a stand-in funcQ.
module tb_funcq_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int MO = 8;
    localparam int IW = 2;

    typedef logic signed [DW-1:0] data_t;
    typedef struct { int id; data_t a; data_t b; data_t c; data_t d; } pend_t;
    typedef struct { int rdy; data_t v; } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_vld;
    logic [NR-1:0]     req_rdy;
    logic [NR*DW-1:0]  req_a, req_b, req_c, req_d;
    logic              data_vld;
    data_t             a, b, c, d;
    logic              Q_vld;
    data_t             Q;
    logic              resp_vld;
    logic [IW-1:0]     resp_id;
    data_t             resp_q;
    logic              busy;
    logic              err_orphan;

    always #5 clk = ~clk;

    funcq_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_OUT(MO), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .data_vld(data_vld), .a(a), .b(b), .c(c), .d(d),
        .Q_vld(Q_vld), .Q(Q),
        .resp_vld(resp_vld), .resp_id(resp_id), .resp_q(resp_q),
        .busy(busy), .err_orphan(err_orphan)
    );

    pend_t pend[$];
    res_t  fq[$];
    int    tags[$];
    int    acc_log[$];
    int    acc_cyc[$];
    int    pop_cyc[$];
    int    m_ptr = 0, cyc = 0, checks = 0, errors = 0, last_rdy = 0;
    int    lat_lo = 1, lat_hi = 1;
    bit    q_en = 1'b0, orphan_inj = 1'b0;
    logic  e_dvld = 1'b0, e_rvld = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    int    e_rid = 0;
    data_t e_a = '0, e_b = '0, e_c = '0, e_d = '0, e_rq = '0;

    // Stand-in for the funcQ datapath; the arbiter never computes, it only forwards.
    function automatic data_t ref_funcq(pend_t p);
        logic signed [31:0] t;
        t = p.a * p.b + p.c * p.d;
        return t[DW-1:0];
    endfunction

    task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic add_req(int id, data_t oa, data_t ob, data_t oc, data_t od);
        pend.push_back('{id, oa, ob, oc, od});
    endtask

    task automatic cycle();
        int    fi [NR];
        int    g, r, idx;
        bit    full, acc, pop, orph, from_fq;
        logic [NR-1:0] erdy;
        pend_t p;

        req_vld = '0;
        for (int i = 0; i < NR; i++) begin
            fi[i] = -1;
            for (int j = 0; j < pend.size(); j++)
                if (fi[i] < 0 && pend[j].id == i) fi[i] = j;
            if (fi[i] >= 0) begin
                req_vld[i]         = 1'b1;
                req_a[i*DW +: DW]  = pend[fi[i]].a;
                req_b[i*DW +: DW]  = pend[fi[i]].b;
                req_c[i*DW +: DW]  = pend[fi[i]].c;
                req_d[i*DW +: DW]  = pend[fi[i]].d;
            end
        end

        from_fq = 1'b0;
        Q_vld   = 1'b0;
        Q       = '0;
        if (orphan_inj) begin
            Q_vld      = 1'b1;
            Q          = 16'sd42;
            orphan_inj = 1'b0;
        end else if (q_en && fq.size() > 0 && fq[0].rdy <= cyc) begin
            Q_vld   = 1'b1;
            Q       = fq[0].v;
            from_fq = 1'b1;
        end
        #1;

        full = (tags.size() == MO);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && req_vld[idx]) g = idx;
        end
        erdy = '0;
        acc  = rst && g >= 0 && !full;
        if (acc) erdy[g] = 1'b1;
        check("req_rdy", req_rdy, erdy);
        for (int i = 0; i < NR; i++)
            if (req_rdy[i] && req_vld[i]) begin
                acc_log.push_back(i);
                acc_cyc.push_back(cyc);
            end
        if (Q_vld) pop_cyc.push_back(cyc);

        pop  = rst && Q_vld && tags.size() > 0;
        orph = rst && Q_vld && tags.size() == 0;
        if (!rst) begin
            tags.delete();
            fq.delete();
            last_rdy = 0;
            m_ptr    = 0;
            e_dvld = 1'b0; e_rvld = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            e_a = '0; e_b = '0; e_c = '0; e_d = '0; e_rq = '0; e_rid = 0;
        end else begin
            e_rvld = pop;
            if (pop) begin
                e_rid = tags.pop_front();
                e_rq  = Q;
            end
            if (from_fq) fq.pop_front();
            if (orph) e_err = 1'b1;
            e_dvld = acc;
            if (acc) begin
                p   = pend[fi[g]];
                e_a = p.a; e_b = p.b; e_c = p.c; e_d = p.d;
                tags.push_back(g);
                m_ptr = (g + 1) % NR;
                r = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
                if (r <= last_rdy) r = last_rdy + 1;
                last_rdy = r;
                fq.push_back('{r, ref_funcq(p)});
                pend.delete(fi[g]);
            end
            e_busy = (tags.size() != 0);
        end

        @(posedge clk);
        #1;
        cyc++;
        check("data_vld", data_vld, e_dvld);
        check("a", a, e_a);
        check("b", b, e_b);
        check("c", c, e_c);
        check("d", d, e_d);
        check("resp_vld", resp_vld, e_rvld);
        if (e_rvld || !rst) begin
            check("resp_id", resp_id, e_rid);
            check("resp_q", resp_q, e_rq);
        end
        check("busy", busy, e_busy);
        check("err_orphan", err_orphan, e_err);
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic drain(int maxc);
        int n;
        n    = 0;
        q_en = 1'b1;
        while ((tags.size() > 0 || pend.size() > 0) && n < maxc) begin
            cycle();
            n++;
        end
        check("drain_done", tags.size() + pend.size(), 0);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        pop_cyc.delete();
    endtask

    initial begin
        int n0, added, n;
        req_vld = '0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        Q_vld = 1'b0;
        Q     = '0;

        // Reset, with all four requesters already waiting before release
        rst = 1'b0;
        idle(2);
        for (int s = 0; s < 2; s++) begin
            add_req(0, 11, 5, -1, 5);
            add_req(1, 12, 3, -2, 1);
            add_req(2, 1, 2, 3, 4);
            add_req(3, -7, 0, 7, 2);
        end
        idle(1);
        rst    = 1'b1;
        q_en   = 1'b1;
        lat_lo = 2;
        lat_hi = 2;
        clear_logs();
        idle(8);
        for (int i = 0; i < 8; i++)
            check("rr_order", (i < acc_log.size()) ? acc_log[i] : -1, i % NR);
        drain(60);

        // Single request from requester 0
        clear_logs();
        add_req(0, 11, 5, -1, 5);
        cycle();
        check("single_grant", (acc_log.size() == 1) ? acc_log[0] : -1, 0);
        drain(30);

        // Full stall: 9 back-to-back requests with results held back
        clear_logs();
        lat_lo = 1;
        lat_hi = 1;
        q_en   = 1'b0;
        for (int i = 0; i < 9; i++)
            add_req(1, data_t'($urandom), data_t'($urandom), data_t'($urandom), data_t'($urandom));
        idle(14);
        check("stall_accepts", acc_cyc.size(), 8);
        q_en = 1'b1;
        idle(2);
        check("ninth_accepted", acc_cyc.size(), 9);
        check("ninth_after_pop", (acc_cyc.size() == 9 && pop_cyc.size() > 0) ? acc_cyc[8] - pop_cyc[0] : -1, 1);
        drain(40);

        // Push and pop together at three outstanding
        clear_logs();
        q_en = 1'b0;
        add_req(0, 100, 1, 2, 3);
        add_req(1, 200, 4, 5, 6);
        add_req(2, 300, 7, 8, 9);
        idle(5);
        add_req(3, -300, 9, -8, 7);
        q_en = 1'b1;
        cycle();
        check("pp_same_cycle", (acc_cyc.size() == 4 && pop_cyc.size() == 1) ? acc_cyc[3] - pop_cyc[0] : -1, 0);
        q_en = 1'b0;
        n0   = acc_cyc.size();
        for (int i = 0; i < 6; i++)
            add_req(0, data_t'($urandom), data_t'($urandom), data_t'($urandom), data_t'($urandom));
        idle(10);
        check("pp_room_left", acc_cyc.size() - n0, 5);
        drain(60);

        // Randomised IDs, operands and latency
        lat_lo = 1;
        lat_hi = 4;
        q_en   = 1'b1;
        added  = 0;
        n      = 0;
        while ((added < 20 || pend.size() > 0 || tags.size() > 0) && n < 400) begin
            if (added < 20 && $urandom_range(1, 0) == 1) begin
                add_req(int'($urandom_range(NR - 1, 0)), data_t'($urandom), data_t'($urandom),
                        data_t'($urandom), data_t'($urandom));
                added++;
            end
            cycle();
            n++;
        end
        check("random_done", tags.size() + pend.size() + (20 - added), 0);

        // Orphan result with nothing outstanding
        orphan_inj = 1'b1;
        cycle();
        idle(3);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle(1);

        // Reset with three operations in flight
        lat_lo = 1;
        lat_hi = 1;
        q_en   = 1'b0;
        add_req(0, 1, 1, 1, 1);
        add_req(1, 2, 2, 2, 2);
        add_req(2, 3, 3, 3, 3);
        idle(4);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        clear_logs();
        add_req(2, 21, -3, 4, 5);
        add_req(3, 31, 6, -7, 8);
        q_en = 1'b1;
        cycle();
        check("rst_first_grant", (acc_log.size() > 0) ? acc_log[0] : -1, 2);
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/funcq_arbiter.md
Name: funcq_arbiter

Overview:
- Round-robin arbiter that shares a single funcQ datapath instance between NUM_REQ requesters.
- Accepts operand sets (a, b, c, d) through a valid/ready handshake and issues them to funcQ one per cycle.
- Tracks requester IDs in an in-order tag FIFO and routes each funcQ result (Q_vld/Q) back, tagged with the ID of its originator.
- Sits between client blocks and funcQ; funcQ is in-order and cannot be stalled.

Parameters:
- DATA_WIDTH, 16, operand/result width (signed), matches funcQ.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUT, 8, maximum funcQ operations in flight (tag FIFO depth, power of 2).
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester operand valid.
- req_rdy  out  NUM_REQ  per-requester accept.
- req_a, req_b, req_c, req_d  in  NUM_REQ*DATA_WIDTH each  flattened signed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- data_vld  out  1  issue strobe to funcQ.
- a, b, c, d  out  DATA_WIDTH each  signed operands to funcQ.
- Q_vld  in  1  result valid from funcQ.
- Q  in  DATA_WIDTH  signed result from funcQ.
- resp_vld  out  1  result valid to clients.
- resp_id  out  ID_W  index of the requester that owns resp_q.
- resp_q  out  DATA_WIDTH  signed result.
- busy  out  1  high while outstanding count is nonzero.
- err_orphan  out  1  sticky flag: Q_vld arrived with the tag FIFO empty.

Behaviour:
- Reset (rst==0 at a clk edge):
  - data_vld, resp_vld, busy and err_orphan go to 0.
  - a, b, c, d, resp_q and resp_id go to 0.
  - RR pointer goes to 0; tag FIFO is flushed (count 0).
  - req_rdy is all-zero while rst==0.
  - Any result in flight at reset is not delivered.
- Arbitration:
  - Combinational, at most one grant per cycle.
  - The winner is the first i with req_vld[i]==1, scanning from ptr upward modulo NUM_REQ.
  - req_rdy[i] = grant[i] & ~full, where full = (count == MAX_OUT) from the registered count. There is no same-cycle bypass from a pop.
  - req_rdy depends only on req_vld, ptr and count. A requester must hold req_vld and its operands stable until it sees req_rdy.
- Accept: req_vld[i] & req_rdy[i] at an edge causes all of the following:
  - Next cycle: data_vld=1 and a..d = the operands of requester i (1-cycle issue latency).
  - Tag i is pushed into the FIFO.
  - ptr <= (i+1) mod NUM_REQ.
- No accept: the next cycle has data_vld=0 and a..d hold their previous values. ptr is unchanged when nothing is granted.
- Back-to-back: a new accept is possible every cycle, so sustained throughput is 1 operation per clock.
- Return path:
  - On Q_vld==1 with count>0: the FIFO pops, and next cycle resp_vld=1, resp_id = popped tag, resp_q = Q (1-cycle latency).
  - resp_vld is a single-cycle pulse per result. Clients cannot backpressure it.
  - On Q_vld==1 with count==0: no pop and resp_vld stays 0. err_orphan is set to 1 and holds until reset.
- Count update:
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged.
  - When count==MAX_OUT, a push is impossible because req_rdy is 0. A pop in the same cycle frees one slot starting from the next cycle.
- busy = (count != 0), registered.
- Arithmetic: the block performs no arithmetic on data. Operands and results pass through bit-exact.
- FIFO pointers wrap modulo MAX_OUT.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends a=11, b=5, c=-1, d=5.
  - Required: data_vld pulses 1 cycle after req_rdy, carrying exactly those operands.
  - Required: resp_vld arrives with resp_id=0 and resp_q = ref_funcQ(11,5,-1,5), 1 cycle after Q_vld.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_vld from reset release, with operand sets (11,5,-1,5), (12,3,-2,1), (1,2,3,4), (-7,0,7,2).
  - Required: grants go 0,1,2,3,0,... on consecutive cycles.
  - Required: responses return in the same ID order, each resp_q matching ref_funcQ of its own operands.
- Full stall:
  - Setup: MAX_OUT=8, with a funcQ model delayed so results do not return.
  - Stimulus: 9 back-to-back requests.
  - Required: the 9th sees req_rdy=0 until the first Q_vld. It is accepted the cycle after that pop, never in the same cycle. busy=1 throughout.
- Simultaneous push and pop at count==3:
  - Required: count stays 3 and the correct tag pops.
  - Required: resp_id ordering is preserved over 20 randomised-ID requests.
- Orphan result: inject Q_vld=1, Q=42 with the FIFO empty.
  - Required: resp_vld stays 0 and err_orphan=1 and stays 1.
  - Required: a subsequent rst=0 cycle clears err_orphan.
- Reset mid-operation:
  - Stimulus: assert rst=0 with 3 operations outstanding.
  - Required: busy=0, resp_vld=0 and ptr=0 after the edge.
  - Required: after release, a new request from requester 2 is granted first and returns with resp_id=2.
